controller_debouncer: RTL



---
 rtl/controller_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 127 ++++++++++++
 rtl/controller_debouncer.sv | 39 +++
 3 files changed

// File: rtl/controller_pkg.sv
// controller_pkg
//   Shared definitions for the breadboard controller front end.
//   - Default channel count and debounce window.
//   - Button index constants matching the btn_* bit order.
//   - Debounce channel state encoding.
package controller_pkg;

   localparam int NUM_BTN_DEF         = 6;
   localparam int DEBOUNCE_CYCLES_DEF = 1000000;  // 10 ms at 100 MHz

   localparam int BTN_LEFT   = 0;
   localparam int BTN_RIGHT  = 1;
   localparam int BTN_UP     = 2;
   localparam int BTN_DOWN   = 3;
   localparam int BTN_ATTACK = 4;
   localparam int BTN_PERY   = 5;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      CHK_HIGH  = 2'd1,
      IDLE_HIGH = 2'd2,
      CHK_LOW   = 2'd3
   } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One input bit: two-flop synchroniser, debounce FSM and stability counter.
//   A change is accepted only after DEBOUNCE_CYCLES consecutive synchronised
//   samples at the new level. Any sample back at the old level restarts the
//   count from zero.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   raw_i     in   raw pin level, asynchronous to clk
//   level_o   out  debounced held level
//   press_o   out  one-cycle strobe on accepted 0->1
//   release_o out  one-cycle strobe on accepted 1->0
module debounce_channel
   import controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             s1_q, s2_q;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;

   // Synchroniser: only s2_q is used by the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= raw_i;
         s2_q <= s1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE_LOW;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // The entering sample counts as the first stable cycle (cnt_d = 1), so
   // acceptance happens on the sample that sees cnt_q == DEBOUNCE_CYCLES-1.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (s2_q) begin
               state_d = CHK_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         CHK_HIGH: begin
            if (!s2_q) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE_HIGH;
               level_d = 1'b1;
               press_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!s2_q) begin
               state_d = CHK_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         CHK_LOW: begin
            if (s2_q) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = IDLE_LOW;
               level_d   = 1'b0;
               release_d = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/controller_debouncer.sv
// controller_debouncer
//   Conditions the raw breadboard controller pins before the decoder. Each
//   channel is synchronised and debounced independently; no priority between
//   directions is applied here.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn_raw      in   raw pins {pery, attack, down, up, right, left}
//   btn_level    out  debounced held levels
//   btn_press    out  one-cycle strobes on accepted 0->1
//   btn_release  out  one-cycle strobes on accepted 1->0
module controller_debouncer
   import controller_pkg::*;
#(
   parameter int NUM_BTN         = NUM_BTN_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release
);

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .raw_i     (btn_raw[g]),
         .level_o   (btn_level[g]),
         .press_o   (btn_press[g]),
         .release_o (btn_release[g])
      );
   end

endmodule
